// File: rtl/wb_commit_unit_if.sv
// rtl/wb_commit_unit_if.sv - shared types and port bundle for the writeback/commit stage
// Optional WB_FWD_EN adds the same-cycle bypass signals.
package wb_commit_pkg;
  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] reg_data_t;

  typedef struct packed {
    logic       rd_we;
    logic [4:0] rd;
  } decode_t;

  typedef struct packed {
    logic      valid;
    reg_data_t code;
    reg_data_t tval;
  } except_t;

  typedef struct packed {
    logic      valid;
    reg_data_t pc;
    decode_t   decode;
    except_t   except;
  } issued_instr_t;
endpackage

interface wb_commit_unit_if #(
  parameter int RETIRE_CNT_W = 64
);
  import wb_commit_pkg::*;

  issued_instr_t           i_instr;
  reg_data_t               i_data;
  reg_data_t               i_trap_vec;
  logic                    o_rf_we;
  logic [4:0]              o_rf_waddr;
  reg_data_t               o_rf_wdata;
  logic                    o_flush;
  logic                    o_redirect_valid;
  reg_data_t               o_redirect_pc;
  reg_data_t               o_trap_cause;
  reg_data_t               o_trap_tval;
  reg_data_t               o_trap_epc;
  logic [RETIRE_CNT_W-1:0] o_retire_cnt;
  logic                    o_busy;
`ifdef WB_FWD_EN
  logic                    o_fwd_valid;
  logic [4:0]              o_fwd_addr;
  reg_data_t               o_fwd_data;
`endif

  modport master (
    output i_instr, i_data, i_trap_vec,
    input  o_rf_we, o_rf_waddr, o_rf_wdata, o_flush, o_redirect_valid, o_redirect_pc,
           o_trap_cause, o_trap_tval, o_trap_epc, o_retire_cnt, o_busy
`ifdef WB_FWD_EN
    , input o_fwd_valid, o_fwd_addr, o_fwd_data
`endif
  );

  modport slave (
    input  i_instr, i_data, i_trap_vec,
    output o_rf_we, o_rf_waddr, o_rf_wdata, o_flush, o_redirect_valid, o_redirect_pc,
           o_trap_cause, o_trap_tval, o_trap_epc, o_retire_cnt, o_busy
`ifdef WB_FWD_EN
    , output o_fwd_valid, o_fwd_addr, o_fwd_data
`endif
  );
endinterface

// File: rtl/wb_commit_unit.sv
// rtl/wb_commit_unit.sv - writeback/commit stage: RF write, retire count, exception flush + drain
// Define WB_FWD_EN to add the combinational bypass outputs.
module wb_commit_unit
  import wb_commit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int RETIRE_CNT_W = 64
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  wb_commit_unit_if.slave wb
);
  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t                  state_q, state_d;
  logic [3:0]              drain_q, drain_d;
  logic                    we_q, we_d;
  logic [4:0]              waddr_q, waddr_d;
  reg_data_t               wdata_q, wdata_d;
  logic                    flush_q, flush_d;
  reg_data_t               rpc_q, rpc_d;
  reg_data_t               cause_q, cause_d;
  reg_data_t               tval_q, tval_d;
  reg_data_t               epc_q, epc_d;
  logic [RETIRE_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      flush_q <= 1'b0;
      rpc_q   <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      epc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      flush_q <= flush_d;
      rpc_q   <= rpc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    we_d    = 1'b0;
    flush_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rpc_d   = rpc_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (wb.i_instr.valid) begin
          // An excepting instruction never commits its own register write.
          if (wb.i_instr.except.valid) begin
            flush_d = 1'b1;
            rpc_d   = {wb.i_trap_vec[XLEN-1:2], 2'b00};
            cause_d = wb.i_instr.except.code;
            tval_d  = wb.i_instr.except.tval;
            epc_d   = wb.i_instr.pc;
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end else begin
            we_d    = wb.i_instr.decode.rd_we && (wb.i_instr.decode.rd != 5'd0);
            waddr_d = wb.i_instr.decode.rd;
            wdata_d = wb.i_data;
            cnt_d   = cnt_q + RETIRE_CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - 4'd1;
        if (drain_q <= 4'd1) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        drain_d = '0;
      end
    endcase
  end

  assign wb.o_rf_we          = we_q;
  assign wb.o_rf_waddr       = waddr_q;
  assign wb.o_rf_wdata       = wdata_q;
  assign wb.o_flush          = flush_q;
  assign wb.o_redirect_valid = flush_q;
  assign wb.o_redirect_pc    = rpc_q;
  assign wb.o_trap_cause     = cause_q;
  assign wb.o_trap_tval      = tval_q;
  assign wb.o_trap_epc       = epc_q;
  assign wb.o_retire_cnt     = cnt_q;
  assign wb.o_busy           = (state_q == ST_DRAIN);

`ifdef WB_FWD_EN
  logic fwd_valid;

  // Gated by reset too, so the bypass never advertises a write that reset will suppress.
  assign fwd_valid      = i_rst_n && (state_q == ST_RUN) && wb.i_instr.valid &&
                          !wb.i_instr.except.valid && wb.i_instr.decode.rd_we &&
                          (wb.i_instr.decode.rd != 5'd0);
  assign wb.o_fwd_valid = fwd_valid;
  assign wb.o_fwd_addr  = fwd_valid ? wb.i_instr.decode.rd : 5'd0;
  assign wb.o_fwd_data  = fwd_valid ? wb.i_data : '0;
`endif
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb/tb_wb_commit_unit.sv - directed table plus randomized model check of wb_commit_unit
module tb_wb_commit_unit;
  import wb_commit_pkg::*;

  localparam int DRAIN = 2;

  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  wb_commit_unit_if #(.RETIRE_CNT_W(64)) ifc ();
  wb_commit_unit_if #(.RETIRE_CNT_W(4))  ifc4 ();

  assign ifc4.i_instr    = ifc.i_instr;
  assign ifc4.i_data     = ifc.i_data;
  assign ifc4.i_trap_vec = ifc.i_trap_vec;

  wb_commit_unit #(.DRAIN_CYCLES(DRAIN), .RETIRE_CNT_W(64)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wb      (ifc.slave)
  );

  wb_commit_unit #(.DRAIN_CYCLES(DRAIN), .RETIRE_CNT_W(4)) dut4 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wb      (ifc4.slave)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic rst_n, input logic valid, input logic exc, input logic rd_we,
                       input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc,
                       input logic [31:0] code, input logic [31:0] tval, input logic [31:0] tv);
    issued_instr_t ins;
    ins.valid         = valid;
    ins.pc            = pc;
    ins.decode.rd_we  = rd_we;
    ins.decode.rd     = rd;
    ins.except.valid  = exc;
    ins.except.code   = code;
    ins.except.tval   = tval;
    i_rst_n           = rst_n;
    ifc.i_instr       = ins;
    ifc.i_data        = data;
    ifc.i_trap_vec    = tv;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    longint rst_n, valid, exc, rd_we, rd, data, pc, code, tval, tv;
    longint e_we, e_wa, e_wd, e_fl, e_rpc, e_cause, e_tval, e_epc, e_cnt, e_busy;
  } vec_t;

  vec_t vecs[16];

  // Behavioural model: inputs on cycle indices up to m_drain_end are discarded.
  logic [63:0] m_cnt;
  int          m_cyc, m_drain_end;
  logic        m_we, m_fl, m_busy;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_rpc, m_cause, m_tval, m_epc;

  task automatic model_step(input logic rst_n, input logic valid, input logic exc, input logic rd_we,
                            input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc,
                            input logic [31:0] code, input logic [31:0] tval, input logic [31:0] tv);
    if (!rst_n) begin
      m_cnt = 0; m_we = 0; m_fl = 0; m_busy = 0; m_wa = 0; m_wd = 0;
      m_rpc = 0; m_cause = 0; m_tval = 0; m_epc = 0; m_drain_end = -1;
    end else begin
      m_we = 0;
      m_fl = 0;
      if (!(m_cyc <= m_drain_end) && valid) begin
        if (exc) begin
          m_fl = 1; m_rpc = tv & 32'hffff_fffc;
          m_cause = code; m_tval = tval; m_epc = pc;
          m_drain_end = m_cyc + DRAIN;
        end else begin
          m_we = rd_we && (rd != 0);
          m_wa = rd; m_wd = data; m_cnt = m_cnt + 1;
        end
      end
      m_busy = (m_cyc + 1) <= m_drain_end;
      m_cyc++;
    end
  endtask

  task automatic check_model();
    chk("rnd_we",    64'(ifc.o_rf_we), 64'(m_we));
    chk("rnd_waddr", 64'(ifc.o_rf_waddr), 64'(m_wa));
    chk("rnd_wdata", 64'(ifc.o_rf_wdata), 64'(m_wd));
    chk("rnd_flush", 64'(ifc.o_flush), 64'(m_fl));
    chk("rnd_rvalid", 64'(ifc.o_redirect_valid), 64'(m_fl));
    chk("rnd_rpc",   64'(ifc.o_redirect_pc), 64'(m_rpc));
    chk("rnd_cause", 64'(ifc.o_trap_cause), 64'(m_cause));
    chk("rnd_tval",  64'(ifc.o_trap_tval), 64'(m_tval));
    chk("rnd_epc",   64'(ifc.o_trap_epc), 64'(m_epc));
    chk("rnd_cnt",   ifc.o_retire_cnt, m_cnt);
    chk("rnd_busy",  64'(ifc.o_busy), 64'(m_busy));
    chk("rnd_cnt4",  64'(ifc4.o_retire_cnt), m_cnt & 64'hf);
    chk("rnd_we4",   64'(ifc4.o_rf_we), 64'(m_we));
  endtask

  initial begin
    m_cyc = 0;
    m_drain_end = -1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vecs[0]  = '{0,0,0,0,0,0,0,0,0,0,                                   0,0,0,0,0,0,0,0,0,0};
    vecs[1]  = '{1,1,0,1,5,'h1234,'h100,0,0,0,                          1,5,'h1234,0,0,0,0,0,1,0};
    vecs[2]  = '{1,1,0,1,0,'h55,'h104,0,0,0,                            0,0,'h55,0,0,0,0,0,2,0};
    vecs[3]  = '{1,0,0,1,9,'h99,'h108,0,0,0,                            0,0,'h55,0,0,0,0,0,2,0};
    vecs[4]  = '{1,1,1,1,7,'h77,'h80001000,13,'hdead0000,'h80000103,
                 0,0,'h55,1,'h80000100,13,'hdead0000,'h80001000,2,1};
    vecs[5]  = '{1,1,0,1,6,'h66,'h80001004,0,0,'h80000103,
                 0,0,'h55,0,'h80000100,13,'hdead0000,'h80001000,2,1};
    vecs[6]  = '{1,1,1,1,6,'h66,'h2000,9,1,'h40,
                 0,0,'h55,0,'h80000100,13,'hdead0000,'h80001000,2,0};
    vecs[7]  = '{1,1,0,1,6,'h77,'h2004,0,0,'h40,
                 1,6,'h77,0,'h80000100,13,'hdead0000,'h80001000,3,0};
    vecs[8]  = '{1,1,1,0,0,0,'h100,2,0,'h30000002,                      0,6,'h77,1,'h30000000,2,0,'h100,3,1};
    vecs[9]  = '{1,1,0,1,1,'h99,'h104,0,0,0,                            0,6,'h77,0,'h30000000,2,0,'h100,3,1};
    vecs[10] = '{0,1,0,1,1,'h99,'h104,0,0,0,                            0,0,0,0,0,0,0,0,0,0};
    vecs[11] = '{1,1,0,1,3,'habc,'h108,0,0,0,                           1,3,'habc,0,0,0,0,0,1,0};
    vecs[12] = '{1,1,1,1,4,1,'h500,5,'h55,'h1000,                       0,3,'habc,1,'h1000,5,'h55,'h500,1,1};
    vecs[13] = '{1,0,0,0,0,0,0,0,0,0,                                   0,3,'habc,0,'h1000,5,'h55,'h500,1,1};
    vecs[14] = '{1,0,0,0,0,0,0,0,0,0,                                   0,3,'habc,0,'h1000,5,'h55,'h500,1,0};
    vecs[15] = '{1,1,1,1,2,2,'h700,7,'h77,'h2004,                       0,3,'habc,1,'h2004,7,'h77,'h700,1,1};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst_n[0], vecs[i].valid[0], vecs[i].exc[0], vecs[i].rd_we[0], 5'(vecs[i].rd),
            32'(vecs[i].data), 32'(vecs[i].pc), 32'(vecs[i].code), 32'(vecs[i].tval), 32'(vecs[i].tv));
      tick();
      chk($sformatf("v%0d_we", i),    64'(ifc.o_rf_we), 64'(vecs[i].e_we));
      chk($sformatf("v%0d_waddr", i), 64'(ifc.o_rf_waddr), 64'(vecs[i].e_wa));
      chk($sformatf("v%0d_wdata", i), 64'(ifc.o_rf_wdata), 64'(vecs[i].e_wd));
      chk($sformatf("v%0d_flush", i), 64'(ifc.o_flush), 64'(vecs[i].e_fl));
      chk($sformatf("v%0d_rvalid", i), 64'(ifc.o_redirect_valid), 64'(vecs[i].e_fl));
      chk($sformatf("v%0d_rpc", i),   64'(ifc.o_redirect_pc), 64'(vecs[i].e_rpc));
      chk($sformatf("v%0d_cause", i), 64'(ifc.o_trap_cause), 64'(vecs[i].e_cause));
      chk($sformatf("v%0d_tval", i),  64'(ifc.o_trap_tval), 64'(vecs[i].e_tval));
      chk($sformatf("v%0d_epc", i),   64'(ifc.o_trap_epc), 64'(vecs[i].e_epc));
      chk($sformatf("v%0d_cnt", i),   ifc.o_retire_cnt, 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d_busy", i),  64'(ifc.o_busy), 64'(vecs[i].e_busy));
    end

    // Counter wrap on the narrow instance: 15 retires reach all-ones, the 16th wraps to 0.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 1, 5'd1, 32'(i), 0, 0, 0, 0);
      tick();
      if (i == 14) chk("wrap_allones", 64'(ifc4.o_retire_cnt), 64'hf);
    end
    chk("wrap_zero", 64'(ifc4.o_retire_cnt), 64'h0);
    chk("wrap_wide", ifc.o_retire_cnt, 64'd16);

    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_v, r_e, r_we;
      logic [4:0]  r_rd;
      logic [31:0] r_d, r_pc, r_code, r_tval, r_tv;
      r_rst  = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      r_v    = ($urandom_range(0, 4) != 0);
      r_e    = ($urandom_range(0, 7) == 0);
      r_we   = ($urandom_range(0, 3) != 0);
      r_rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r_d    = $urandom;
      r_pc   = $urandom;
      r_code = $urandom_range(0, 15);
      r_tval = $urandom;
      r_tv   = $urandom;
      drive(r_rst, r_v, r_e, r_we, r_rd, r_d, r_pc, r_code, r_tval, r_tv);
`ifdef WB_FWD_EN
      #1;
      begin
        logic f_v;
        f_v = r_rst && !(m_cyc <= m_drain_end) && r_v && !r_e && r_we && (r_rd != 0);
        chk("fwd_valid", 64'(ifc.o_fwd_valid), 64'(f_v));
        chk("fwd_addr",  64'(ifc.o_fwd_addr), f_v ? 64'(r_rd) : 64'd0);
        chk("fwd_data",  64'(ifc.o_fwd_data), f_v ? 64'(r_d) : 64'd0);
      end
`endif
      model_step(r_rst, r_v, r_e, r_we, r_rd, r_d, r_pc, r_code, r_tval, r_tv);
      tick();
      check_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
